// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control-unit FSM that walks one instruction at a time through
// fetch, decode, dispatch, execute, memory and write-back. It owns the memory
// handshake (with a bus-fault timeout), the decoder enable pulse, the per-stage
// datapath strobes, run/step/halt control and the retired-instruction counter.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        Step,
  input  logic [6:0]  OP,
  input  logic        FLTo,
  input  logic        MemAck,
  output logic        MemReq,
  output logic        MemSel,
  output logic        MemWr,
  output logic        IR_ld,
  output logic        PC_inc,
  output logic        E,
  output logic        BranchEn,
  output logic        ExecEn,
  output logic        RegWr,
  output logic [2:0]  State,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_EXEC     = 3'd4,
    S_MEM      = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  // The wait counter holds 0..MEM_TIMEOUT-1; reaching the last value without
  // an ack is the fault condition.
  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LD    = 7'd33;
  localparam logic [6:0] OP_ST    = 7'd34;
  localparam logic [6:0] OP_LDR   = 7'd39;
  localparam logic [6:0] OP_STR   = 7'd40;
  localparam logic [6:0] OP_BKPT  = 7'd41;
  localparam logic [6:0] OP_BRMAX = 7'd8;

  state_t        state_r;
  logic          fault_r;
  logic [15:0]   count_r;
  logic [TW-1:0] tmo_r;
  logic          run_prev_r;
  logic          store_r;

  logic mem_req_s, mem_sel_s, mem_wr_s, ir_ld_s, pc_inc_s;
  logic e_s, branch_en_s, exec_en_s, reg_wr_s;

  // Opcode classes that need a data-memory phase.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_LDR) || (op == OP_STR);
  endfunction

  // Opcode classes whose data phase is a write.
  function automatic logic is_store_op(input logic [6:0] op);
    return (op == OP_ST) || (op == OP_STR);
  endfunction

  // Per-stage strobes decoded from the current state, fetch gated by the ack.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_sel_s   = 1'b0;
    mem_wr_s    = 1'b0;
    ir_ld_s     = 1'b0;
    pc_inc_s    = 1'b0;
    e_s         = 1'b0;
    branch_en_s = 1'b0;
    exec_en_s   = 1'b0;
    reg_wr_s    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        ir_ld_s   = MemAck;
        pc_inc_s  = MemAck;
      end
      S_DECODE:   e_s = 1'b1;
      S_DISPATCH: branch_en_s = !FLTo && (OP <= OP_BRMAX);
      S_EXEC:     exec_en_s = 1'b1;
      S_MEM: begin
        mem_req_s = 1'b1;
        mem_sel_s = 1'b1;
        mem_wr_s  = store_r;
      end
      S_WB:       reg_wr_s = 1'b1;
      default:    mem_req_s = 1'b0;
    endcase
  end

  // Sequencer state, fault flag, memory wait counter and retire counter.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_r    <= S_IDLE;
      fault_r    <= 1'b0;
      count_r    <= 16'd0;
      tmo_r      <= '0;
      run_prev_r <= 1'b0;
      store_r    <= 1'b0;
    end else begin
      run_prev_r <= Run;
      case (state_r)
        S_IDLE: begin
          if (Run || Step) begin
            state_r <= S_FETCH;
            tmo_r   <= '0;
          end
        end
        S_FETCH: begin
          if (MemAck) begin
            state_r <= S_DECODE;
          end else if (tmo_r == TMO_LAST) begin
            fault_r <= 1'b1;
            state_r <= S_HALT;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        S_DECODE: state_r <= S_DISPATCH;
        S_DISPATCH: begin
          if (FLTo) begin
            fault_r <= 1'b1;
            state_r <= S_HALT;
          end else if (OP == OP_BKPT) begin
            state_r <= S_HALT;
          end else if (is_mem_op(OP)) begin
            state_r <= S_MEM;
            store_r <= is_store_op(OP);
            tmo_r   <= '0;
          end else if (OP <= OP_BRMAX) begin
            count_r <= count_r + 16'd1;
            state_r <= Run ? S_FETCH : S_IDLE;
            tmo_r   <= '0;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: state_r <= S_WB;
        S_MEM: begin
          if (MemAck) begin
            if (store_r) begin
              count_r <= count_r + 16'd1;
              state_r <= Run ? S_FETCH : S_IDLE;
              tmo_r   <= '0;
            end else begin
              state_r <= S_WB;
            end
          end else if (tmo_r == TMO_LAST) begin
            fault_r <= 1'b1;
            state_r <= S_HALT;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        S_WB: begin
          count_r <= count_r + 16'd1;
          state_r <= Run ? S_FETCH : S_IDLE;
          tmo_r   <= '0;
        end
        S_HALT: begin
          // A faulted halt is left only through reset; a breakpoint resumes.
          if (!fault_r && (Step || (Run && !run_prev_r))) begin
            state_r <= S_FETCH;
            tmo_r   <= '0;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign MemReq     = mem_req_s;
  assign MemSel     = mem_sel_s;
  assign MemWr      = mem_wr_s;
  assign IR_ld      = ir_ld_s;
  assign PC_inc     = pc_inc_s;
  assign E          = e_s;
  assign BranchEn   = branch_en_s;
  assign ExecEn     = exec_en_s;
  assign RegWr      = reg_wr_s;
  assign State      = state_r;
  assign Halted     = (state_r == S_IDLE) || (state_r == S_HALT);
  assign Fault      = fault_r;
  assign InstrCount = count_r;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Control-unit state machine that sequences one instruction at a time through fetch, decode, execute, memory and write-back for the basic CPU. It owns the memory request handshake, pulses the instruction decoder's enable `E`, and classifies the decoded `OP`/`FLTo` to choose the execution path. It also raises the per-stage strobes for the PC, IR, ALU, branch unit and register file. It sits between the memory interface and the decoder/datapath, and provides run/step/halt control plus a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, 15: maximum cycles `MemReq` may stay high without `MemAck` before a bus fault (≥1)
- `Clock`  in  1  system clock; all state changes on posedge
- `Reset_n`  in  1  synchronous, active-low reset
- `Run`  in  1  level; high = execute continuously
- `Step`  in  1  one-cycle pulse; executes exactly one instruction when not running
- `OP`  in  7  opcode from instruction decoder
- `FLTo`  in  1  decoder invalid-instruction flag
- `MemAck`  in  1  memory completion for current request
- `MemReq`  out  1  memory request, held until ack/timeout
- `MemSel`  out  1  address select: 0 = PC (fetch), 1 = data address
- `MemWr`  out  1  1 = write (ST/STR data phase)
- `IR_ld`  out  1  load instruction register
- `PC_inc`  out  1  increment PC by 2
- `E`  out  1  decoder enable, one-cycle pulse
- `BranchEn`  out  1  branch unit evaluate/update PC
- `ExecEn`  out  1  ALU/CEX/misc execute strobe
- `RegWr`  out  1  register-file write-back
- `State`  out  3  current state encoding
- `Halted`  out  1  high in IDLE or HALT
- `Fault`  out  1  sticky fault flag
- `InstrCount`  out  16  retired instruction count

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, DISPATCH=3, EXEC=4, MEM=5, WB=6, HALT=7.
- Reset (`Reset_n`=0 at posedge): State=IDLE, Fault=0, InstrCount=0, timeout counter=0. All strobes are low and `Halted`=1.
- Strobes are combinational decodes of State, gated with `MemAck` where noted.
- IDLE: if `Run` or `Step`, go to FETCH.
- FETCH: `MemReq`=1, `MemSel`=0, `MemWr`=0. On `MemAck`, `IR_ld`=1 and `PC_inc`=1 in the same cycle, then go to DECODE.
- DECODE: `E`=1 for this cycle only, then go to DISPATCH. The decoder outputs are valid in DISPATCH.
- DISPATCH applies the first matching rule:
  - `FLTo`=1: set Fault and go to HALT.
  - `OP`=41 (breakpoint): go to HALT with Fault=0.
  - `OP` ∈ {33,34,39,40}: go to MEM.
  - `OP` ≤ 8 (BL..BRA): `BranchEn`=1 and retire.
  - Otherwise: go to EXEC.
- EXEC: `ExecEn`=1, then go to WB.
- MEM: `MemReq`=1, `MemSel`=1, `MemWr`=1 if `OP` ∈ {34,40}. On `MemAck`, loads go to WB and stores retire.
- WB: `RegWr`=1, then retire.
- Retire: InstrCount+1 (wraps FFFF→0000). Next state is FETCH if `Run`=1, else IDLE.
- HALT:
  - With Fault=1, the only exit is reset.
  - With Fault=0 (breakpoint), a `Step` or a rising `Run` goes to FETCH. InstrCount is not incremented for the breakpoint.
- `Step` is ignored outside IDLE/HALT.
- Dropping `Run` mid-instruction completes that instruction, then goes to IDLE.
- Timeout counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle `MemReq`=1 without `MemAck`.
  - If it reaches `MEM_TIMEOUT` with no ack, set Fault and go to HALT. `MemReq` drops in the next cycle.
  - `MemAck` arriving in the same cycle as expiry wins: it is a normal completion.

## Timing
- Minimum cycles per instruction, with `MemAck` in the first request cycle:
  - Branch: 3 (FETCH, DECODE, DISPATCH).
  - ALU: 5.
  - ST/STR: 4.
  - LD/LDR: 5.
- Each extra memory wait cycle adds 1.
- InstrCount updates on the posedge that leaves the retiring state.
- `E` is never high for two consecutive cycles. `IR_ld` always precedes `E` by exactly 1 cycle.
- Reset asserted in any state, including mid-handshake, takes effect at the next posedge. `MemReq` is low in the following cycle.

## Test plan
- Reset, `Run`=1, memory acks immediately, instruction ADD (`OP`=9): State visits 1,2,3,4,6,1 → `ExecEn` and `RegWr` each high 1 cycle, InstrCount=1 after 5 cycles.
- `Step` pulse with `Run`=0, LD (`OP`=33), data ack delayed 3 cycles: `MemSel`=1 and `MemWr`=0 for 4 cycles, then `RegWr`, then IDLE with InstrCount=1.
- STR (`OP`=40): `MemWr`=1 during MEM, no `RegWr`, retires after ack. BEQ (`OP`=1): `BranchEn` 1 cycle, 3-cycle instruction.
- `FLTo`=1 in DISPATCH → Fault=1, State=7, `Run`/`Step` ignored, cleared only by `Reset_n`=0. Breakpoint (`OP`=41) → HALT with Fault=0, then `Step` resumes fetch.
- `MEM_TIMEOUT`=15, `MemAck` never arrives → Fault set after 15 request cycles. Separately, ack on the 15th cycle → normal completion, Fault=0.
- Preload InstrCount to FFFF by running 65535 branches, retire one more → 0000. Assert `Reset_n`=0 during a FETCH wait → IDLE, `MemReq`=0 next cycle.
